// File: rtl/monostable_pkg.sv
// Shared definitions for the multi-channel monostable pulse generator.
package monostable_pkg;

  // Trigger edge selection codes (2'b11 behaves like EDGE_RISE).
  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  // Per-channel pulse state.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Pick the trigger from the detected edges according to the edge selector.
  function automatic logic edge_trigger(input logic       rise,
                                        input logic       fall,
                                        input logic [1:0] sel);
    logic trig;
    case (sel)
      EDGE_FALL: trig = fall;
      EDGE_BOTH: trig = rise | fall;
      default:   trig = rise;
    endcase
    return trig;
  endfunction

endpackage

// File: rtl/monostable_ch.sv
// One monostable channel: input synchroniser, edge detector, pulse FSM with
// down-counter, and a sticky overrun flag for dropped triggers.
module monostable_ch
  import monostable_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic             clk32_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             data_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic             retrig_i,
  input  logic [1:0]       edge_sel_i,
  input  logic             clr_i,
  output logic             data_o,
  output logic             overrun_o
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   overrun_reg, overrun_next;

  logic sync_last;
  logic rise, fall, trig;
  logic width_ok;
  logic last_cycle;
  logic load;
  logic drop;

  // Synchroniser chain plus the previous-sample flop used by the edge detector.
  always_ff @(posedge clk32_i) begin
    if (rst_i) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], data_i};
      prev_reg <= sync_last;
    end
  end

  // Edge detection runs regardless of enable_i, so an input held high across
  // a re-enable does not look like a fresh edge.
  assign sync_last  = sync_reg[SYNC_STAGES-1];
  assign rise       = sync_last & ~prev_reg;
  assign fall       = ~sync_last & prev_reg;
  assign trig       = edge_trigger(rise, fall, edge_sel_i);
  assign width_ok   = (width_i != '0);
  assign last_cycle = (cnt_reg == CNT_W'(1));

  // A trigger starts or reloads a pulse from IDLE, on any retrigger, or in the
  // final active cycle (back-to-back pulse). A zero width never loads.
  assign load = enable_i & trig & width_ok &
                ((state_reg == ST_IDLE) | retrig_i | last_cycle);

  // Non-retriggerable channel still counting: the trigger is lost. A zero
  // width in this situation is also treated as a lost trigger.
  assign drop = enable_i & trig & (state_reg == ST_ACTIVE) &
                ~retrig_i & ~last_cycle;

  // FSM state and counter registers.
  always_ff @(posedge clk32_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          state_next = ST_ACTIVE;
          cnt_next   = width_i;
        end
      end
      ST_ACTIVE: begin
        if (!enable_i) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (load) begin
          cnt_next   = width_i;
        end else if (last_cycle) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pulse output comes straight from the state flop.
  always_comb begin
    data_o = (state_reg == ST_ACTIVE);
  end

  // Sticky overrun flag; a new drop wins over a simultaneous clear.
  always_comb begin
    overrun_next = drop | (overrun_reg & ~clr_i);
  end

  // Overrun flag register.
  always_ff @(posedge clk32_i) begin
    if (rst_i) begin
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= overrun_next;
    end
  end

  assign overrun_o = overrun_reg;

endmodule

// File: rtl/monostable_multi.sv
// Multi-channel monostable: replicates one independent channel per input bit
// and fans the shared controls out to all of them.
module monostable_multi
  import monostable_pkg::*;
#(
  parameter int CH          = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk32_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [CH-1:0]    data_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic             retrig_i,
  input  logic [1:0]       edge_sel_i,
  input  logic             clr_i,
  output logic [CH-1:0]    data_o,
  output logic [CH-1:0]    overrun_o
);

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      monostable_ch #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
        .clk32_i    (clk32_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .data_i     (data_i[gi]),
        .width_i    (width_i),
        .retrig_i   (retrig_i),
        .edge_sel_i (edge_sel_i),
        .clr_i      (clr_i),
        .data_o     (data_o[gi]),
        .overrun_o  (overrun_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_monostable_multi.sv
module tb_monostable_multi;

    localparam int CH    = 4;
    localparam int CNT_W = 8;

    logic             clk32_i = 1'b0;
    logic             rst_i;
    logic             enable_i;
    logic [CH-1:0]    data_i;
    logic [CNT_W-1:0] width_i;
    logic             retrig_i;
    logic [1:0]       edge_sel_i;
    logic             clr_i;
    logic [CH-1:0]    data_o;
    logic [CH-1:0]    overrun_o;

    always #5 clk32_i = ~clk32_i;

    monostable_multi #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk32_i    (clk32_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .data_i     (data_i),
        .width_i    (width_i),
        .retrig_i   (retrig_i),
        .edge_sel_i (edge_sel_i),
        .clr_i      (clr_i),
        .data_o     (data_o),
        .overrun_o  (overrun_o)
    );

    typedef struct {
        int            cyc;
        logic [CH-1:0] d;
        logic [CH-1:0] ov;
        int            tid;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always @(posedge clk32_i) cyc <= cyc + 1;

    always @(negedge clk32_i) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                tests_run++;
                if (data_o !== sb[i].d || overrun_o !== sb[i].ov) begin
                    tests_failed++;
                    $display("FAIL t%0d edge %0d: data_o=%b overrun_o=%b, expected data_o=%b overrun_o=%b",
                             sb[i].tid, cyc, data_o, overrun_o, sb[i].d, sb[i].ov);
                end else begin
                    $display("[TB] t%0d edge %0d ok data_o=%b overrun_o=%b",
                             sb[i].tid, cyc, data_o, overrun_o);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk32_i);
        #1;
    endtask

    task automatic push(input int e, input logic [CH-1:0] d,
                        input logic [CH-1:0] ov, input int tid);
        exp_t x;
        x.cyc = e;
        x.d   = d;
        x.ov  = ov;
        x.tid = tid;
        sb.push_back(x);
    endtask

    task automatic push_win(input int k, input int n, input int ch,
                            input int lo, input int hi, input int ov_from,
                            input int tid);
        logic [CH-1:0] d;
        logic [CH-1:0] ov;
        for (int e = 0; e < n; e++) begin
            d  = '0;
            ov = '0;
            if (e >= lo && e <= hi) d[ch] = 1'b1;
            if (ov_from >= 0 && e >= ov_from) ov[ch] = 1'b1;
            push(k + e, d, ov, tid);
        end
    endtask

    task automatic rise_twice(input int ch);
        data_i[ch] = 1'b1;
        tick();
        data_i[ch] = 1'b0;
        tick();
        tick();
        data_i[ch] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [CH-1:0] d;

        rst_i      = 1'b1;
        enable_i   = 1'b1;
        data_i     = '0;
        width_i    = '0;
        retrig_i   = 1'b0;
        edge_sel_i = 2'b00;
        clr_i      = 1'b0;

        push(1, '0, '0, 0);
        push(2, '0, '0, 0);
        push(3, '0, '0, 0);
        repeat (3) tick();
        tests_run++;
        if (data_o !== '0 || overrun_o !== '0) begin
            tests_failed++;
            $display("FAIL t0 edge %0d: data_o=%b overrun_o=%b, expected data_o=0000 overrun_o=0000",
                     cyc, data_o, overrun_o);
        end else begin
            $display("[TB] t0 edge %0d ok in reset data_o=%b overrun_o=%b", cyc, data_o, overrun_o);
        end
        rst_i = 1'b0;

        width_i = 8'd5;
        k = cyc + 1;
        push_win(k, 10, 0, 2, 6, -1, 1);
        data_i[0] = 1'b1;
        repeat (12) tick();
        data_i[0] = 1'b0;
        repeat (4) tick();

        retrig_i = 1'b1;
        width_i  = 8'd6;
        k = cyc + 1;
        push_win(k, 13, 1, 2, 10, -1, 2);
        rise_twice(1);
        repeat (14) tick();
        data_i[1] = 1'b0;
        repeat (4) tick();

        retrig_i = 1'b0;
        k = cyc + 1;
        push_win(k, 12, 1, 2, 7, 5, 3);
        rise_twice(1);
        repeat (12) tick();
        data_i[1] = 1'b0;
        tick();
        clr_i = 1'b1;
        push(cyc + 1, '0, '0, 3);
        tick();
        clr_i = 1'b0;
        repeat (3) tick();

        k = cyc + 1;
        push_win(k, 9, 1, 2, 7, 5, 4);
        rise_twice(1);
        tick();
        tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        repeat (6) tick();
        data_i[1] = 1'b0;
        tick();
        clr_i = 1'b1;
        push(cyc + 1, '0, '0, 4);
        tick();
        clr_i = 1'b0;
        repeat (3) tick();

        edge_sel_i = 2'b10;
        width_i    = 8'd2;
        k = cyc + 1;
        for (int e = 0; e < 16; e++) begin
            d = '0;
            if ((e >= 2 && e <= 3) || (e >= 12 && e <= 13)) d[2] = 1'b1;
            push(k + e, d, '0, 5);
        end
        data_i[2] = 1'b1;
        repeat (10) tick();
        data_i[2] = 1'b0;
        repeat (8) tick();

        edge_sel_i = 2'b01;
        k = cyc + 1;
        push_win(k, 16, 2, 12, 13, -1, 6);
        data_i[2] = 1'b1;
        repeat (10) tick();
        data_i[2] = 1'b0;
        repeat (8) tick();
        edge_sel_i = 2'b00;

        width_i = 8'd0;
        k = cyc + 1;
        push_win(k, 8, 3, 1, 0, -1, 7);
        data_i[3] = 1'b1;
        repeat (8) tick();
        data_i[3] = 1'b0;
        repeat (3) tick();

        width_i = 8'd255;
        k = cyc + 1;
        push_win(k, 260, 0, 2, 256, -1, 8);
        data_i[0] = 1'b1;
        tick();
        data_i[0] = 1'b0;
        repeat (262) tick();

        width_i = 8'd4;
        k = cyc + 1;
        push_win(k, 12, 3, 2, 9, -1, 9);
        data_i[3] = 1'b1;
        tick();
        tick();
        data_i[3] = 1'b0;
        tick();
        tick();
        data_i[3] = 1'b1;
        repeat (10) tick();
        data_i[3] = 1'b0;
        repeat (3) tick();

        width_i = 8'd10;
        k = cyc + 1;
        push_win(k, 9, 0, 2, 4, -1, 10);
        data_i[0] = 1'b1;
        repeat (5) tick();
        enable_i = 1'b0;
        repeat (5) tick();

        k = cyc + 1;
        push_win(k, 8, 0, 1, 0, -1, 11);
        enable_i = 1'b1;
        repeat (9) tick();
        data_i[0] = 1'b0;
        repeat (3) tick();

        k = cyc + 1;
        push_win(k, 6, 0, 2, 5, 5, 12);
        push(k + 6, '0, '0, 12);
        push(k + 7, '0, '0, 12);
        rise_twice(0);
        tick();
        tick();
        tick();
        rst_i  = 1'b1;
        data_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
        repeat (4) tick();

        tests_run++;
        if (data_o !== '0 || overrun_o !== '0) begin
            tests_failed++;
            $display("FAIL t12 edge %0d: data_o=%b overrun_o=%b, expected data_o=0000 overrun_o=0000",
                     cyc, data_o, overrun_o);
        end else begin
            $display("[TB] t12 edge %0d ok idle after reset data_o=%b overrun_o=%b", cyc, data_o, overrun_o);
        end

        foreach (sb[i]) begin
            tests_run++;
            tests_failed++;
            $display("FAIL t%0d edge %0d: not checked, expected data_o=%b overrun_o=%b",
                     sb[i].tid, sb[i].cyc, sb[i].d, sb[i].ov);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/monostable_multi.md
Name: monostable_multi

Overview:
- Multi-channel, parametrised pulse generator (monostable).
- Each channel synchronises an asynchronous input and detects a selectable edge on it. The edge fires an output pulse whose length is set at runtime.
- Channels can run in retriggerable or non-retriggerable mode. In non-retriggerable mode, missed triggers are flagged.
- Sits between the demodulator's raw bit-transition outputs and the DPLL phase detector, replacing the fixed 4-cycle stretcher.

Parameters:
- CH, 4, number of independent channels.
- CNT_W, 8, width of the pulse-length counter and of width_i.
- SYNC_STAGES, 2, input synchroniser depth (minimum 2).

Ports:
- clk32_i  in  1  system clock (32x bit rate); all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  global enable; low aborts pulses and ignores triggers.
- data_i  in  CH  asynchronous trigger inputs, one bit per channel.
- width_i  in  CNT_W  pulse length in clk32_i cycles, sampled at each accepted trigger.
- retrig_i  in  1  1 = retriggerable, 0 = non-retriggerable.
- edge_sel_i  in  2  trigger edge: 00 rise, 01 fall, 10 both, 11 treated as rise.
- clr_i  in  1  clears all overrun_o flags.
- data_o  out  CH  pulse outputs, registered.
- overrun_o  out  CH  sticky flag: a trigger was dropped in non-retriggerable mode.

Behaviour:
- Reset (rst_i=1 at an edge):
  - Clears synchroniser flops, the previous-sample flop, counter, data_o and overrun_o.
  - Takes effect at that edge, mid-pulse included.
  - The first cycle after reset produces no spurious edge, because prev = sync = 0.
- Synchroniser: a SYNC_STAGES-flop chain per channel, followed by a prev flop on the last stage.
- Edge detect (combinational on the last stage s and prev p):
  - rise = s & ~p
  - fall = ~s & p
  - trigger is selected per edge_sel_i.
  - The detector runs regardless of enable_i, so re-enabling while an input is held high does not fire.
- Per-channel FSM, states IDLE and ACTIVE; data_o = (state == ACTIVE), registered.
- Trigger acceptance from IDLE:
  - Requires trigger & enable_i & (width_i != 0).
  - Action: go to ACTIVE and load cnt = width_i.
  - width_i = 0: the trigger is ignored silently (no pulse, no overrun).
- Counting in ACTIVE:
  - cnt decrements each cycle.
  - When cnt == 1 and no trigger is accepted, return to IDLE.
  - The pulse is high for exactly width_i cycles (at most 2^CNT_W - 1).
- Latency: with data_i changing just before sampling edge k, data_o rises after edge k+SYNC_STAGES.
- Trigger in ACTIVE, retrig_i=1: reload cnt = width_i (current value). The pulse ends width_i cycles after the reload edge; there is no gap.
- Trigger in ACTIVE, retrig_i=0, cnt > 1: trigger dropped, overrun_o set.
- Trigger in ACTIVE, retrig_i=0, cnt == 1 (last cycle): accepted as a new pulse with no gap; overrun_o not set.
- Retrigger when width_i = 0 is a special case:
  - In retrig mode the channel instead ends the pulse at the normal time.
  - In non-retrig mode the trigger is treated as dropped (overrun set if cnt > 1).
- width_i changes mid-pulse do not affect the running pulse.
- enable_i low: every ACTIVE channel goes to IDLE at the next edge (data_o=0), and triggers are ignored without setting overrun.
- overrun_o: cleared by clr_i. A set and a clr in the same cycle resolve as set (the flag reads 1).
- retrig_i and edge_sel_i are global and may change at any time; they take effect on the next trigger evaluation.
- Channels are fully independent; there are no cross-channel priorities.

Decomposition:
- Package monostable_pkg holds:
  - EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10.
  - State encoding ST_IDLE, ST_ACTIVE.
- Sub-module monostable_ch (one channel: synchroniser, edge detect, FSM, counter, overrun), instantiated CH times in a generate loop.
- The top level only fans out the shared controls.

Test Plan (all cases CH=4, CNT_W=8, SYNC_STAGES=2, enable_i=1, edge_sel_i=00 unless stated):
- Basic pulse: reset 3 cycles, width_i=5, ch0 data_i rises before edge 10 -> data_o[0] is 1 after edges 12..16 and 0 after edge 17; overrun_o=0; other channels stay 0.
- Retrigger: retrig_i=1, width_i=6, ch1 edges sampled at edges 0 and 3 -> data_o[1] rises after edge 2 and stays high until 0 after edge 11, with no gap.
- Non-retrigger/overrun: retrig_i=0, width_i=6, same stimulus -> data_o[1] low after edge 8 and overrun_o[1]=1. A clr_i pulse clears it. clr_i coincident with a new drop leaves it at 1.
- Edge select: edge_sel_i=10, width_i=2, ch2 sees a high pulse of 10 cycles -> two 2-cycle pulses, each 2 edges after its respective input edge. With edge_sel_i=01, only the trailing pulse appears.
- Boundaries: width_i=0 trigger -> no pulse, no overrun. width_i=255 -> a 255-cycle pulse. With retrig_i=0, a trigger landing exactly in the last active cycle -> continuous high for 2×width_i cycles, overrun_o=0.
- Abort and re-enable:
  - enable_i low mid-pulse -> data_o=0 next edge.
  - Re-enable with data_i held high -> no pulse.
  - rst_i mid-pulse -> all outputs 0 after that edge.
